shift_sequencer: RTL
====================

# shift_sequencer

Iterative shift controller for the single-cycle MIPS core. It executes SLL/SRL/SRA and their variable forms SLLV/SRLV/SRAV one bit per clock, and stalls the core through a start/busy/done handshake while the operation runs. The shift amount is the 5-bit shamt field or rs[4:0], zero-extended. The block sits beside the ALU and is started by the main decoder.

## Interface
- DATA_W, 32, operand/result width
- CNT_W, 5, shift-amount width; max shift = 2^CNT_W − 1
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only when accepting (IDLE or DONE)
- op  input  2  2'b00 SLL, 2'b01 SRL, 2'b10 SRA, 2'b11 reserved
- var_sel  input  1  1: amount = rs[CNT_W-1:0]; 0: amount = shamt
- shamt  input  CNT_W  instruction shamt field
- rs  input  DATA_W  rs operand; only low CNT_W bits used
- rt  input  DATA_W  value to shift
- busy  output  1  high in SHIFT; the core stalls on busy
- done  output  1  one-cycle completion pulse
- err  output  1  with done; op was reserved
- result  output  DATA_W  last completed result; held between completions

## Operation
- States: IDLE, SHIFT, DONE.
- Accept occurs when start=1 in IDLE or DONE:
  - latch rt into work register, op into op register;
  - count = var_sel ? rs[CNT_W-1:0] : shamt, zero-extended; upper rs bits ignored.
- Transitions after accept:
  - op = 2'b11 → DONE; err=1; result unchanged.
  - count = 0 → DONE; result = rt.
  - otherwise → SHIFT.
- SHIFT, each cycle:
  - work shifted by one: SLL {w[DATA_W-2:0],0}, SRL {0,w[DATA_W-1:1]}, SRA {w[DATA_W-1],w[DATA_W-1:1]};
  - count decremented.
  - When count = 1 before the decrement: result is loaded with the shifted value and the state goes to DONE.
- DONE lasts one cycle with done=1.
  - Without start → IDLE.
  - With start → accept (back-to-back).
- start in SHIFT is ignored; no queuing.
- Inputs other than start are sampled only on the accept cycle.

## Timing
- Reset values (async, immediate on rst_n low): state IDLE, busy 0, done 0, err 0, result 0, count 0, work 0.
- Accept at edge N, amount k:
  - busy high for cycles N+1 … N+k;
  - done high for cycle N+k+1.
- Amount 0 or reserved op: busy never high; done in cycle N+1.
- Worst case, k=31: done in cycle N+32.
- result updates only on the edge that enters DONE and is stable while done=1. err is valid only with done.
- Reset asserted mid-SHIFT:
  - operation is aborted; no done pulse;
  - result returns to 0.
  - After rst_n rises, the first edge is in IDLE.

## Structure
- Package mips_shift_pkg holds:
  - op encodings OP_SLL/OP_SRL/OP_SRA/OP_RSVD;
  - state enum IDLE/SHIFT/DONE;
  - default widths.
- Sub-module shift1_step is purely combinational: op and word in, one-bit-shifted word out, instantiated once. The controller holds the FSM, counter and registers.

## Test plan
- Reset with rst_n low mid-operation → all outputs 0 asynchronously; no done pulse after release.
- SLL, rt=32'h0000_0001, shamt=4, var_sel=0 → busy for 4 cycles, done in cycle N+5, result=32'h0000_0010, err=0.
- SRAV, rt=32'h8000_0000, rs=32'hFFFF_FFE1 (amount 1 from low bits) → done in cycle N+2, result=32'hC000_0000.
- SRL, amount 0, rt=32'hDEAD_BEEF → busy never high, done in cycle N+1, result=32'hDEAD_BEEF. Then SRL by 31 on 32'h8000_0000 → done in cycle N+32, result=32'h0000_0001.
- start pulsed during SHIFT → ignored; result is from the first op only. start held in the DONE cycle → new op accepted, done pulses back-to-back at the expected latency.
- op=2'b11 → done and err in cycle N+1; result keeps its previous value.

Source files
------------

// File: rtl/mips_shift_pkg.sv
// Shared encodings and widths for the iterative MIPS shift sequencer.
package mips_shift_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int CNT_W_DEF  = 5;

  localparam logic [1:0] OP_SLL  = 2'b00;
  localparam logic [1:0] OP_SRL  = 2'b01;
  localparam logic [1:0] OP_SRA  = 2'b10;
  localparam logic [1:0] OP_RSVD = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/shift_sequencer_shift1_step.sv
// Combinational single-bit shifter: one step of SLL/SRL/SRA per call.
module shift1_step
  import mips_shift_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [1:0]        op_i,
  input  logic [DATA_W-1:0] word_i,
  output logic [DATA_W-1:0] word_o
);

  always_comb begin
    word_o = word_i;
    case (op_i)
      OP_SLL:  word_o = {word_i[DATA_W-2:0], 1'b0};
      OP_SRL:  word_o = {1'b0, word_i[DATA_W-1:1]};
      OP_SRA:  word_o = {word_i[DATA_W-1], word_i[DATA_W-1:1]};
      default: word_o = word_i;
    endcase
  end

endmodule

// File: rtl/shift_sequencer.sv
// Iterative shift controller: one bit per clock, start/busy/done handshake.
// Handshake: start is sampled only in IDLE or DONE; busy is high while shifting,
// done is a one-cycle pulse and err/result are meaningful while done is high.
module shift_sequencer
  import mips_shift_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic              var_sel,
  input  logic [CNT_W-1:0]  shamt,
  input  logic [DATA_W-1:0] rs,
  input  logic [DATA_W-1:0] rt,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] result,
  output logic [1:0]        dbg_state
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] work_q, work_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [1:0]        op_q, op_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              err_q, err_d;

  logic [DATA_W-1:0] shifted;
  logic [CNT_W-1:0]  amount;
  logic              accept;
  logic              unused_rs_hi;

  // Only the low amount bits of rs are architecturally meaningful.
  assign unused_rs_hi = ^rs[DATA_W-1:CNT_W];

  shift1_step #(.DATA_W(DATA_W)) u_step (
    .op_i   (op_q),
    .word_i (work_q),
    .word_o (shifted)
  );

  assign amount = var_sel ? rs[CNT_W-1:0] : shamt;
  assign accept = start && ((state_q == IDLE) || (state_q == DONE));

  always_comb begin
    state_d  = state_q;
    work_d   = work_q;
    count_d  = count_q;
    op_d     = op_q;
    result_d = result_q;
    err_d    = err_q;
    case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          work_d  = rt;
          op_d    = op;
          count_d = amount;
          err_d   = 1'b0;
          if (op == OP_RSVD) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else if (amount == '0) begin
            result_d = rt;
            state_d  = DONE;
          end else begin
            state_d = SHIFT;
          end
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        work_d  = shifted;
        count_d = count_q - {{(CNT_W-1){1'b0}}, 1'b1};
        // Last step: publish the shifted word on the same edge that enters DONE.
        if (count_q == {{(CNT_W-1){1'b0}}, 1'b1}) begin
          result_d = shifted;
          state_d  = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      work_q   <= '0;
      count_q  <= '0;
      op_q     <= OP_SLL;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      work_q   <= work_d;
      count_q  <= count_d;
      op_q     <= op_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

  assign busy      = (state_q == SHIFT);
  assign done      = (state_q == DONE);
  assign err       = err_q && (state_q == DONE);
  assign result    = result_q;
  assign dbg_state = state_q;

endmodule
